// File: rtl/m_shift_reg_param_if.sv
// Bus bundle for m_shift_reg_param: control, serial/parallel data in, stage contents and counter out.
interface m_shift_reg_param_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   w_en;
    logic [1:0]             w_mode;
    logic [WIDTH-1:0]       w_sin;
    logic [WIDTH*DEPTH-1:0] w_pin;
    logic [WIDTH*DEPTH-1:0] w_pout;
    logic [WIDTH-1:0]       w_sout_r;
    logic [WIDTH-1:0]       w_sout_l;
    logic [CW-1:0]          w_left;
    logic                   w_empty;

    modport master (
        output w_en, w_mode, w_sin, w_pin,
        input  w_pout, w_sout_r, w_sout_l, w_left, w_empty
    );

    modport slave (
        input  w_en, w_mode, w_sin, w_pin,
        output w_pout, w_sout_r, w_sout_l, w_left, w_empty
    );
endinterface

// File: rtl/m_shift_reg_param.sv
// DEPTH x WIDTH bidirectional shift register with parallel load, clock enable and a
// count of loaded stages still to be shifted out (serialiser / delay line).
module m_shift_reg_param #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    m_shift_reg_param_if.slave    bus
);
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic [DEPTH-1:0][WIDTH-1:0] stages;
    logic [CW-1:0]               left_q;
    op_e                         op;

    assign op = op_e'(bus.w_mode);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            stages <= '0;
            left_q <= '0;
        end else if (bus.w_en) begin
            case (op)
                OP_SHR: begin
                    // Enters at the top stage, leaves at stage 0.
                    stages <= {bus.w_sin, stages[DEPTH-1:1]};
                    if (left_q != '0) left_q <= left_q - CW'(1);
                end
                OP_SHL: begin
                    stages <= {stages[DEPTH-2:0], bus.w_sin};
                    if (left_q != '0) left_q <= left_q - CW'(1);
                end
                OP_LOAD: begin
                    stages <= bus.w_pin;
                    left_q <= CW'(DEPTH);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.w_pout   = stages;
    assign bus.w_sout_r = stages[0];
    assign bus.w_sout_l = stages[DEPTH-1];
    assign bus.w_left   = left_q;
    assign bus.w_empty  = (left_q == '0);
endmodule

// File: doc/m_shift_reg_param.md
Name: m_shift_reg_param

Overview:
- Parametrised successor to the team's fixed 4-stage serial shift register.
- Generalised to DEPTH stages of WIDTH bits each; supports bidirectional shift, parallel load, hold and clock enable.
- Tracks how many loaded stages have not yet been shifted out, so it can serve as a parallel-to-serial converter (serialiser) or as a plain delay line in the datapath.

Parameters:
- WIDTH, 1, bits per stage (lane width); must be >= 1.
- DEPTH, 4, number of stages; must be >= 2.
- CW, $clog2(DEPTH+1), width of the remaining-stage counter (derived; do not override).

Ports:
- w_clk  input  1  clock; all state changes on its rising edge.
- w_rst  input  1  synchronous active-high reset.
- w_en  input  1  clock enable; 0 = hold all state.
- w_mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- w_sin  input  WIDTH  serial input lane.
- w_pin  input  WIDTH*DEPTH  parallel load data; stage k = bits [k*WIDTH +: WIDTH].
- w_pout  output  WIDTH*DEPTH  all stages, registered; same stage packing as w_pin.
- w_sout_r  output  WIDTH  stage 0 (right-shift serial output).
- w_sout_l  output  WIDTH  stage DEPTH-1 (left-shift serial output).
- w_left  output  CW  loaded stages not yet shifted out.
- w_empty  output  1  1 when w_left == 0.

Behaviour:
- Reset and clock:
  - One clock domain (w_clk). Reset is synchronous and active-high (w_rst).
  - w_rst has priority over w_en and w_mode.
  - On reset: all stages = 0, w_left = 0, w_empty = 1. Consequently w_pout = 0, w_sout_r = 0, w_sout_l = 0.
- Outputs:
  - All outputs are direct register outputs or decodes of registers; there is no combinational path from any input to any output.
  - Latency: an input sampled at edge N is visible on outputs after edge N.
- w_en = 0: stages and w_left hold, whatever w_mode is.
- With w_en = 1, w_mode selects the operation:
  - 00 hold: no change to stages or w_left.
  - 01 shift right: stage k <= stage k+1 for k = 0..DEPTH-2; stage DEPTH-1 <= w_sin; old stage 0 is discarded. This matches the existing serial register: data enters at the top and exits at stage 0. A value on w_sin reaches w_sout_r after DEPTH edges.
  - 10 shift left: stage k <= stage k-1 for k = 1..DEPTH-1; stage 0 <= w_sin; old stage DEPTH-1 is discarded. A value reaches w_sout_l after DEPTH edges.
  - 11 parallel load: every stage <= the corresponding slice of w_pin; w_left <= DEPTH.
- w_left counter:
  - Each shift (01 or 10) decrements w_left, saturating at 0 (never wraps to all-ones).
  - Load always sets w_left = DEPTH, including a reload while w_left > 0; no underflow or overflow is flagged.
  - Shifting with w_left = 0 is legal: data keeps moving and w_left stays 0.
  - w_empty = (w_left == 0), decoded from the register, so it updates on the same edge as w_left.
- Serialiser timing: a load at edge N, followed by shifts at edges N+1..N+DEPTH, gives w_left = 0 and w_empty = 1 after edge N+DEPTH.
  - Shift right: loaded stage 0 is on w_sout_r in cycle N+1, and loaded stage j appears on w_sout_r after edge N+j.
  - Shift left: loaded stage DEPTH-1 is on w_sout_l in cycle N+1.
- Direction may change between consecutive cycles; each edge applies only the current w_mode.
- Reset mid-shift or mid-serialisation clears everything on that edge; partial data is lost.
- X on w_sin or w_pin propagates only into the stages it is loaded or shifted into. X on w_mode with w_en = 1 is illegal stimulus; the bench asserts against it.

Test Plan:
- WIDTH=1, DEPTH=4: reset, then w_en=1, mode=01, w_sin=1 held -> w_sout_r is 0 after edges 1..3 and 1 after edge 4; w_pout=4'b1111 after edge 4; w_left stays 0 and w_empty stays 1 throughout.
- WIDTH=8, DEPTH=4: load w_pin=32'hDDCCBBAA, then 4 right shifts with w_sin=8'h00 -> w_left goes 4,3,2,1,0; w_sout_r reads AA after the load, then BB, CC, DD, 00; w_empty=1 only after the 4th shift.
- WIDTH=8, DEPTH=4: load 32'hDDCCBBAA, then left shifts with w_sin=8'h11 -> w_sout_l reads DD, CC, BB, AA, 11; after 4 shifts w_pout=32'h11111111.
- Enable and hold: load 32'h04030201, then w_en=0 with mode=01 for 3 cycles, then mode=00 with w_en=1 for 2 cycles -> w_pout stays 32'h04030201 and w_left stays 4 for all 5 cycles.
- Saturation and reload: load, 6 right shifts -> w_left reaches 0 and stays 0 (no wrap). Load again after 2 shifts -> w_left returns to 4.
- Mid-operation reset: load 32'hFFFFFFFF, shift once, assert w_rst together with mode=11 -> after that edge w_pout=0, w_left=0, w_empty=1. Also run with DEPTH=2 and WIDTH=3 to cover the parameter corners.
